// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequencing FSM for the floating-point CORDIC datapath.
// Drives the per-iteration shift amount, latches the rotation direction,
// launches the shared FP add/sub stage and strobes the x/y/z register writes.
// No arithmetic lives here: only control, the iteration count and handshakes.
//
// Build option: define CORDIC_GAIN_COMP_EN to add the SCALE/SWAIT gain
// compensation phase (mul_start/mul_done). When it is undefined, mul_start is
// tied low and mul_done is ignored; the port list is the same in both builds.
module cordic_iter_ctrl #(
    parameter int I = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 z_sign,
    input  logic                 add_done,
    input  logic                 mul_done,
    output logic                 busy,
    output logic                 load,
    output logic                 add_start,
    output logic [$clog2(I)-1:0] shift_amt,
    output logic                 dir,
    output logic                 upd,
    output logic                 mul_start,
    output logic                 done
);

    localparam int CW = $clog2(I);
    localparam logic [CW-1:0] ITER_LAST = CW'(I - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [2:0] S_SCALE  = 3'd5;
    localparam logic [2:0] S_SWAIT  = 3'd6;
`endif
    localparam logic [2:0] S_DONE   = 3'd7;

    // A single-stage count wraps nothing below two iterations; refuse to build.
    if (I < 2) begin : g_bad_iter_count
        $error("cordic_iter_ctrl: I must be at least 2");
    end

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] iter;
    logic [CW-1:0] iter_nxt;
    logic          last_iter;

    assign last_iter = (iter == ITER_LAST);

    // Next-state decode; every wait state holds until its handshake arrives.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (add_done) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_nxt = S_SCALE;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_SCALE: begin
                state_nxt = S_SWAIT;
            end
            S_SWAIT: begin
                if (mul_done) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Iteration index: cleared on LOAD and on return to IDLE, bumped only when
    // leaving a non-final UPDATE so it can never wrap past I-1.
    always_comb begin
        iter_nxt = iter;
        if ((state_nxt == S_LOAD) || (state_nxt == S_IDLE)) begin
            iter_nxt = '0;
        end else if ((state == S_UPDATE) && !last_iter) begin
            iter_nxt = iter + CW'(1);
        end
    end

    // State and iteration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            iter  <= iter_nxt;
        end
    end

    // Registered strobes decoded from the upcoming state so each pulse lines
    // up exactly with the cycle the FSM spends in the matching state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            load      <= 1'b0;
            add_start <= 1'b0;
            upd       <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            load      <= (state_nxt == S_LOAD);
            add_start <= (state_nxt == S_ISSUE);
            upd       <= (state_nxt == S_UPDATE);
            done      <= (state_nxt == S_DONE);
        end
    end

    // Direction is captured from the residual-angle sign while in ISSUE, then
    // held untouched through WAIT and UPDATE of that iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir <= 1'b0;
        end else if (state == S_ISSUE) begin
            dir <= ~z_sign;
        end
    end

    // The shifter amount is the iteration register itself.
    assign shift_amt = iter;

`ifdef CORDIC_GAIN_COMP_EN
    // Gain-compensation launch pulse for the one cycle spent in SCALE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_start <= 1'b0;
        end else begin
            mul_start <= (state_nxt == S_SCALE);
        end
    end
`else
    logic unused_mul_done;

    assign mul_start       = 1'b0;
    assign unused_mul_done = mul_done;
`endif

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl (I=8). Stimulus pushes the expected
// pulse events (kind, cycle, shift amount, direction) into a queue; a monitor
// pops and compares whenever the DUT raises any strobe.
module tb_cordic_iter_ctrl;

    localparam int I = 8;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int DONE_OFS = 28;
`else
    localparam int DONE_OFS = 26;
`endif

    localparam int K_LOAD = 0;
    localparam int K_ADD  = 1;
    localparam int K_UPD  = 2;
    localparam int K_MUL  = 3;
    localparam int K_DONE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       z_sign;
    logic       add_done;
    logic       mul_done;
    logic       busy;
    logic       load;
    logic       add_start;
    logic [2:0] shift_amt;
    logic       dir;
    logic       upd;
    logic       mul_start;
    logic       done;

    typedef struct {
        int kind;
        int cyc;
        int shamt;
        int dir;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int lat[8];
    bit pat[8];
    int stray_it;
    bit zglitch;
`ifdef CORDIC_GAIN_COMP_EN
    bit mul_hold = 1'b0;
`endif

    cordic_iter_ctrl #(.I(I)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .z_sign    (z_sign),
        .add_done  (add_done),
        .mul_done  (mul_done),
        .busy      (busy),
        .load      (load),
        .add_start (add_start),
        .shift_amt (shift_amt),
        .dir       (dir),
        .upd       (upd),
        .mul_start (mul_start),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int k, input int c, input int sh, input int d);
        exp_t e;
        e.kind  = k;
        e.cyc   = c;
        e.shamt = sh;
        e.dir   = d;
        sbq.push_back(e);
    endtask

    // Expected events for a rotation whose start is sampled in cycle s.
    // tail: 0 = stop after 'iters' iterations, 1 = full ending, 2 = mul_start only.
    task automatic push_rotation(input int s, input int iters, input int tail);
        int t;
        int u;
        push_exp(K_LOAD, s + 1, -1, -1);
        t = s + 2;
        u = t;
        for (int n = 0; n < iters; n++) begin
            push_exp(K_ADD, t, n, -1);
            u = t + lat[n] + 1;
            push_exp(K_UPD, u, n, pat[n] ? 0 : 1);
            t = u + 1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        if (tail != 0) push_exp(K_MUL, u + 1, -1, -1);
        if (tail == 1) push_exp(K_DONE, u + 3, -1, -1);
`else
        if (tail == 1) push_exp(K_DONE, u + 1, -1, -1);
`endif
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic goto_cyc(input int c);
        if (cyc > c) begin
            checks++;
            errors++;
            $display("FAIL schedule: at cycle %0d, expected to be at or before %0d", cyc, c);
        end
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        goto_cyc(c);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_add_start"}, add_start, 0);
        chk({tag, "_upd"}, upd, 0);
        chk({tag, "_mul_start"}, mul_start, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_shift_amt"}, shift_amt, 0);
    endtask

    task automatic defaults();
        for (int n = 0; n < 8; n++) begin
            lat[n] = 1;
            pat[n] = 1'b0;
        end
        stray_it = -1;
        zglitch  = 1'b0;
    endtask

    // Monitor: every strobe seen must match the head of the scoreboard.
    always @(negedge clk) begin
        int   k;
        int   npulse;
        exp_t e;
        k = -1;
        npulse = 0;
        if (load)      begin k = K_LOAD; npulse++; end
        if (add_start) begin k = K_ADD;  npulse++; end
        if (upd)       begin k = K_UPD;  npulse++; end
        if (mul_start) begin k = K_MUL;  npulse++; end
        if (done)      begin k = K_DONE; npulse++; end
        if (npulse > 1) begin
            checks++;
            errors++;
            $display("FAIL sb_overlap: %0d strobes high together at cycle %0d, expected at most 1", npulse, cyc);
        end
        if (k >= 0) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: strobe kind %0d at cycle %0d, expected none", k, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.kind != k || e.cyc != cyc ||
                    (e.shamt >= 0 && e.shamt != int'(shift_amt)) ||
                    (e.dir >= 0 && e.dir != int'(dir))) begin
                    errors++;
                    $display("FAIL sb_event: got kind=%0d cyc=%0d shamt=%0d dir=%0d, expected kind=%0d cyc=%0d shamt=%0d dir=%0d",
                             k, cyc, shift_amt, dir, e.kind, e.cyc, e.shamt, e.dir);
                end
            end
        end
    end

    // Add/sub stage model: result valid lat[n] cycles after add_start,
    // optionally held one extra cycle into UPDATE.
    initial begin
        int n;
        add_done = 1'b0;
        forever begin
            @(negedge clk);
            if (add_start) begin
                n = int'(shift_amt);
                repeat (lat[n]) @(posedge clk);
                #1 add_done = 1'b1;
                @(posedge clk);
                #1;
                if (n == stray_it) begin
                    @(posedge clk);
                    #1;
                end
                add_done = 1'b0;
            end
        end
    end

    // Residual-angle sign: set during ISSUE, optionally flipped during WAIT.
    initial begin
        z_sign = 1'b0;
        forever begin
            @(negedge clk);
            if (add_start) begin
                z_sign = pat[shift_amt];
                if (zglitch) begin
                    @(negedge clk);
                    z_sign = ~z_sign;
                end
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // Gain multiplier model: result one cycle after mul_start unless withheld.
    initial begin
        mul_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mul_start && !mul_hold) begin
                @(posedge clk);
                #1 mul_done = 1'b1;
                @(posedge clk);
                #1 mul_done = 1'b0;
            end
        end
    end
`else
    // Without gain compensation mul_done must be ignored; keep it asserted.
    initial mul_done = 1'b1;
`endif

    initial begin
        int s;
        int s2;
        rst_n = 1'b0;
        start = 1'b0;
        defaults();

        // Reset state
        at_neg(3);
        chk_all_zero("reset");
        goto_cyc(4);
        rst_n = 1'b1;

        // Reference rotation, z_sign = 0 throughout
        s = 6;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 8, 1);
        @(posedge clk);
        #1 start = 1'b0;
        at_neg(s + 1);
        chk("ref_load_c1", load, 1);
        chk("ref_busy_c1", busy, 1);
        at_neg(s + DONE_OFS);
        chk("ref_done", done, 1);
        chk("ref_busy_at_done", busy, 1);
        at_neg(s + DONE_OFS + 1);
        chk("ref_busy_after_done", busy, 0);

        // Alternating z_sign with a glitch during every WAIT
        s = s + DONE_OFS + 4;
        for (int n = 0; n < 8; n++) pat[n] = n[0];
        zglitch = 1'b1;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 8, 1);
        @(posedge clk);
        #1 start = 1'b0;
        at_neg(s + 7);
        chk("alt_dir_iter1", dir, 0);
        at_neg(s + 10);
        chk("alt_dir_iter2", dir, 1);
        at_neg(s + DONE_OFS);
        chk("alt_done", done, 1);
        defaults();

        // Iteration 3 completes 4 cycles after add_start; stray add_done in UPDATE of iteration 5
        s = s + DONE_OFS + 4;
        lat[3] = 4;
        stray_it = 5;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 8, 1);
        @(posedge clk);
        #1 start = 1'b0;
        at_neg(s + 13);
        chk("delay_shift_held", shift_amt, 3);
        chk("delay_busy", busy, 1);
        at_neg(s + DONE_OFS + 3);
        chk("delay_done", done, 1);
        defaults();

        // Reset during UPDATE of iteration 2, then a clean rotation
        s = s + DONE_OFS + 6;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 3, 0);
        @(posedge clk);
        #1 start = 1'b0;
        goto_cyc(s + 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        at_neg(s + 11);
        chk_all_zero("abort");
        s = s + 14;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 8, 1);
        @(posedge clk);
        #1 start = 1'b0;
        at_neg(s + 2);
        chk("restart_shift0", shift_amt, 0);
        at_neg(s + DONE_OFS);
        chk("restart_done", done, 1);

        // start held high: back-to-back rotations, nothing captured while busy
        s = s + DONE_OFS + 4;
        s2 = s + DONE_OFS + 1;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 8, 1);
        push_rotation(s2, 8, 1);
        at_neg(s + DONE_OFS + 1);
        chk("b2b_idle_gap_busy", busy, 0);
        at_neg(s2 + 1);
        chk("b2b_second_load", load, 1);
        start = 1'b0;
        at_neg(s2 + DONE_OFS);
        chk("b2b_second_done", done, 1);

        // start pulse during DONE is dropped
        s = s2 + DONE_OFS + 4;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 8, 1);
        @(posedge clk);
        #1 start = 1'b0;
        goto_cyc(s + DONE_OFS);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        at_neg(s + DONE_OFS + 1);
        chk("drop_busy", busy, 0);
        chk("drop_load", load, 0);
        at_neg(s + DONE_OFS + 2);
        chk("drop_load_later", load, 0);

`ifdef CORDIC_GAIN_COMP_EN
        // mul_done withheld: FSM parks in SWAIT with busy high
        s = s + DONE_OFS + 5;
        mul_hold = 1'b1;
        goto_cyc(s);
        start = 1'b1;
        push_rotation(s, 8, 2);
        @(posedge clk);
        #1 start = 1'b0;
        at_neg(s + 26);
        chk("swait_mul_start", mul_start, 1);
        at_neg(s + 32);
        chk("swait_busy", busy, 1);
        chk("swait_no_done", done, 0);
        goto_cyc(s + 33);
        mul_done = 1'b1;
        push_exp(K_DONE, s + 34, -1, -1);
        @(posedge clk);
        #1 mul_done = 1'b0;
        at_neg(s + 34);
        chk("swait_done", done, 1);
        mul_hold = 1'b0;
`endif

        at_neg(cyc + 6);
        chk("sb_drain", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
